// File: rtl/aes_encrypt_core_param.sv
// Iterative AES-128/192/256 encryption core with on-chip key expansion, one round per clock.
// Optional CBC chaining is compiled in by defining AES_ENC_CBC_EN; the default build is ECB only.
module aes_encrypt_core_param #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_load,
  output logic                key_ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_block,
  input  logic [127:0]        iv_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_block
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_encrypt_core_param: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic {K_IDLE, K_EXPAND} key_state_t;
  typedef enum logic [1:0] {E_IDLE, E_ROUND, E_DONE} enc_state_t;

  key_state_t k_state;
  enc_state_t e_state;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, with 0 mapping to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int n = 0; n < 16; n++) o[8*n +: 8] = sbox(s[8*n +: 8]);
    return o;
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; row = n%4, column = n/4
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s));
    if (!last)
      t = {mix_col(t[127:96]), mix_col(t[95:64]), mix_col(t[63:32]), mix_col(t[31:0])};
    return t ^ rk;
  endfunction

  logic [31:0]  w [NW];
  logic [5:0]   widx;
  logic [3:0]   kmod;
  logic [7:0]   rcon;
  logic [31:0]  prev_word;
  logic [31:0]  temp_word;
  logic [31:0]  new_word;
  logic         key_go;

  logic [127:0] state_reg;
  logic [3:0]   round;
  logic [5:0]   rk_base;
  logic [127:0] rk_cur;
  logic [127:0] rk_zero;
  logic [127:0] round_out;
  logic [127:0] pre_block;
  logic         accept;

  assign key_go   = key_load && (e_state == E_IDLE);
  assign in_ready = key_ready && (e_state == E_IDLE) && (k_state == K_IDLE);
  assign accept   = in_valid && in_ready;

  // kmod tracks i mod Nk so the RotWord/Rcon and AES-256 extra SubWord steps need no divider
  always_comb begin
    prev_word = w[widx - 6'd1];
    temp_word = prev_word;
    if (kmod == 4'd0)
      temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h000000};
    else if (NK == 8 && kmod == 4'd4)
      temp_word = sub_word(prev_word);
    new_word = w[widx - 6'(NK)] ^ temp_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_state   <= K_IDLE;
      key_ready <= 1'b0;
      widx      <= 6'd0;
      kmod      <= 4'd0;
      rcon      <= 8'h01;
    end else if (key_go) begin
      k_state   <= K_EXPAND;
      key_ready <= 1'b0;
      widx      <= 6'(NK);
      kmod      <= 4'd0;
      rcon      <= 8'h01;
    end else if (k_state == K_EXPAND) begin
      if (kmod == 4'd0) rcon <= xtime(rcon);
      kmod <= (kmod == 4'(NK - 1)) ? 4'd0 : kmod + 4'd1;
      widx <= widx + 6'd1;
      if (widx == 6'(NW - 1)) begin
        k_state   <= K_IDLE;
        key_ready <= 1'b1;
      end
    end
  end

  // The round-key store deliberately has no reset; key_ready guards its validity
  always_ff @(posedge clk) begin
    if (key_go) begin
      for (int j = 0; j < NK; j++) w[j] <= key_in[KEY_BITS-1-32*j -: 32];
    end else if (k_state == K_EXPAND) begin
      w[widx] <= new_word;
    end
  end

  always_comb begin
    rk_base   = {round, 2'b00};
    rk_cur    = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    rk_zero   = {w[0], w[1], w[2], w[3]};
    round_out = aes_round(state_reg, rk_cur, round == 4'(NR));
  end

`ifdef AES_ENC_CBC_EN
  logic [127:0] chain;
  logic         use_iv;

  assign pre_block = in_block ^ (use_iv ? iv_in : chain);

  // A fresh key always restarts the chain from iv_in
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain  <= 128'h0;
      use_iv <= 1'b1;
    end else begin
      if (key_go)      use_iv <= 1'b1;
      else if (accept) use_iv <= 1'b0;
      if (e_state == E_ROUND && round == 4'(NR)) chain <= round_out;
    end
  end
`else
  logic unused_iv;
  assign unused_iv = ^iv_in;
  assign pre_block = in_block;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_state   <= E_IDLE;
      state_reg <= 128'h0;
      round     <= 4'd0;
      out_block <= 128'h0;
      out_valid <= 1'b0;
    end else begin
      case (e_state)
        E_IDLE: begin
          if (accept) begin
            state_reg <= pre_block ^ rk_zero;
            round     <= 4'd1;
            e_state   <= E_ROUND;
          end
        end
        E_ROUND: begin
          if (round == 4'(NR)) begin
            out_block <= round_out;
            out_valid <= 1'b1;
            e_state   <= E_DONE;
          end else begin
            state_reg <= round_out;
            round     <= round + 4'd1;
          end
        end
        E_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            e_state   <= E_IDLE;
          end
        end
        default: e_state <= E_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core_param.sv
// Directed bench for aes_encrypt_core_param: one instance per key size sharing clock and reset.
// The AES_ENC_CBC_EN build swaps the final ECB repeat-block step for the SP800-38A CBC vectors.
module tb_aes_encrypt_core_param;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] key_bus;
  logic [127:0] in_block;
  logic [127:0] iv_in;
  logic         key_load  [3];
  logic         key_ready [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_block [3];

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] APP_PT   = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  aes_encrypt_core_param #(.KEY_BITS(128)) dut128 (
    .clk(clk), .reset_n(reset_n), .key_in(key_bus[127:0]), .key_load(key_load[0]),
    .key_ready(key_ready[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_block(in_block), .iv_in(iv_in), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_block(out_block[0]));

  aes_encrypt_core_param #(.KEY_BITS(192)) dut192 (
    .clk(clk), .reset_n(reset_n), .key_in(key_bus[191:0]), .key_load(key_load[1]),
    .key_ready(key_ready[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_block(in_block), .iv_in(iv_in), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_block(out_block[1]));

  aes_encrypt_core_param #(.KEY_BITS(256)) dut256 (
    .clk(clk), .reset_n(reset_n), .key_in(key_bus), .key_load(key_load[2]),
    .key_ready(key_ready[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_block(in_block), .iv_in(iv_in), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_block(out_block[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input int sel, input logic [255:0] key, input int exp_cycles,
                          input string tag);
    int n;
    key_bus = key;
    key_load[sel] = 1'b1;
    step();
    key_load[sel] = 1'b0;
    check({tag, "/key_ready_drop"}, 128'(key_ready[sel]), 128'd0);
    n = 0;
    while (key_ready[sel] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check({tag, "/expand_cycles"}, 128'(n), 128'(exp_cycles));
  endtask

  task automatic start_block(input int sel, input logic [127:0] pt, input string tag);
    int n;
    n = 0;
    while (in_ready[sel] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check({tag, "/in_ready"}, 128'(in_ready[sel]), 128'd1);
    in_block = pt;
    in_valid[sel] = 1'b1;
    step();
    in_valid[sel] = 1'b0;
  endtask

  task automatic wait_output(input int sel, input int start, input int exp_lat,
                             input logic [127:0] exp_ct, input string tag);
    int n;
    n = start;
    while (out_valid[sel] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check({tag, "/latency"}, 128'(n), 128'(exp_lat));
    check({tag, "/ciphertext"}, out_block[sel], exp_ct);
  endtask

  task automatic handshake(input int sel, input string tag);
    out_ready[sel] = 1'b1;
    step();
    out_ready[sel] = 1'b0;
    check({tag, "/out_valid_drop"}, 128'(out_valid[sel]), 128'd0);
    check({tag, "/in_ready_after"}, 128'(in_ready[sel]), 128'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    reset_n  = 1'b0;
    key_bus  = 256'h0;
    in_block = 128'h0;
    iv_in    = 128'h0;
    for (int i = 0; i < 3; i++) begin
      key_load[i]  = 1'b0;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    step();
    step();
    check("reset/key_ready", 128'(key_ready[0]), 128'd0);
    check("reset/in_ready", 128'(in_ready[0]), 128'd0);
    check("reset/out_valid", 128'(out_valid[0]), 128'd0);
    check("reset/out_block", out_block[0], 128'h0);
    reset_n = 1'b1;
    step();

    $display("[TB] FIPS-197 vectors for all three key sizes");
    load_key(0, 256'(FIPS_KEY), 40, "k128");
    start_block(0, FIPS_PT, "k128");
    wait_output(0, 0, 10, FIPS_CT, "k128");
    handshake(0, "k128");

    load_key(1, 256'(192'h000102030405060708090a0b0c0d0e0f1011121314151617), 46, "k192");
    start_block(1, APP_PT, "k192");
    wait_output(1, 0, 12, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "k192");
    handshake(1, "k192");

    load_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 52, "k256");
    start_block(2, APP_PT, "k256");
    wait_output(2, 0, 14, 128'h8ea2b7ca516745bfeafc49904b496089, "k256");
    handshake(2, "k256");

    $display("[TB] output backpressure");
    load_key(0, 256'(FIPS_KEY), 40, "bp");
    start_block(0, FIPS_PT, "bp");
    wait_output(0, 0, 10, FIPS_CT, "bp");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid[0] !== 1'b1 || out_block[0] !== FIPS_CT || in_ready[0] !== 1'b0) bad++;
    end
    check("bp/stable_cycles_bad", 128'(bad), 128'd0);
    handshake(0, "bp");

    $display("[TB] key_load during rounds is dropped");
    load_key(0, 256'(FIPS_KEY), 40, "kl_round");
    start_block(0, FIPS_PT, "kl_round");
    step();
    step();
    key_bus = 256'h0;
    key_load[0] = 1'b1;
    step();
    key_load[0] = 1'b0;
    check("kl_round/key_ready_kept", 128'(key_ready[0]), 128'd1);
    wait_output(0, 3, 10, FIPS_CT, "kl_round");
    handshake(0, "kl_round");

    $display("[TB] key_load mid-expansion restarts");
    key_bus = 256'h0;
    key_load[0] = 1'b1;
    step();
    key_load[0] = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("restart/key_ready_mid", 128'(key_ready[0]), 128'd0);
    load_key(0, 256'(FIPS_KEY), 40, "restart");
    start_block(0, FIPS_PT, "restart");
    wait_output(0, 0, 10, FIPS_CT, "restart");
    handshake(0, "restart");

    $display("[TB] reset during round 5");
    start_block(0, FIPS_PT, "rst_mid");
    for (int i = 0; i < 5; i++) step();
    reset_n = 1'b0;
    #1;
    check("rst_mid/out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_mid/key_ready", 128'(key_ready[0]), 128'd0);
    check("rst_mid/in_ready", 128'(in_ready[0]), 128'd0);
    check("rst_mid/out_block", out_block[0], 128'h0);
    step();
    reset_n = 1'b1;
    step();
    check("rst_mid/key_ready_after", 128'(key_ready[0]), 128'd0);
    load_key(0, 256'(FIPS_KEY), 40, "rst_reload");
    start_block(0, FIPS_PT, "rst_reload");
    wait_output(0, 0, 10, FIPS_CT, "rst_reload");
    handshake(0, "rst_reload");

`ifdef AES_ENC_CBC_EN
    $display("[TB] CBC chain, SP800-38A F.2.1");
    iv_in = 128'h000102030405060708090a0b0c0d0e0f;
    load_key(0, 256'(FIPS_KEY), 40, "cbc");
    start_block(0, 128'h6bc1bee22e409f96e93d7e117393172a, "cbc0");
    wait_output(0, 0, 10, 128'h7649abac8119b246cee98e9b12e9197d, "cbc0");
    handshake(0, "cbc0");
    start_block(0, 128'hae2d8a571e03ac9c9eb76fac45af8e51, "cbc1");
    wait_output(0, 0, 10, 128'h5086cb9b507219ee95db113a917678b2, "cbc1");
    handshake(0, "cbc1");
    start_block(0, 128'h30c81c46a35ce411e5fbc1191a0a52ef, "cbc2");
    wait_output(0, 0, 10, 128'h73bed6b8e3c1743b7116e69e22229516, "cbc2");
    handshake(0, "cbc2");
    start_block(0, 128'hf69f2445df4f9b17ad2b417be66c3710, "cbc3");
    wait_output(0, 0, 10, 128'h3ff1caa1681fac09120eca307586e1a7, "cbc3");
    handshake(0, "cbc3");
`else
    $display("[TB] ECB repeat block under the same key");
    start_block(0, FIPS_PT, "ecb_repeat");
    wait_output(0, 0, 10, FIPS_CT, "ecb_repeat");
    handshake(0, "ecb_repeat");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_core_param.md
Name: aes_encrypt_core_param

Overview:
Iterative AES encryption engine, generalised from the fixed AES-128 encrypt top to AES-128, AES-192 and AES-256, selected by a parameter.
- Expands the cipher key once into an internal round-key store, then encrypts any number of blocks under that key.
- Valid/ready handshakes on both input and output.
- Sits between the host-side block FIFO and the ciphertext sink; one round per clock.

Parameters:
KEY_BITS, 128, key length. Legal values 128/192/256; Nk = KEY_BITS/32, Nr = Nk+6. Any other value is an elaboration error.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
key_in  in  KEY_BITS  cipher key, FIPS-197 byte order, MSB = first byte
key_load  in  1  single-cycle request to expand key_in
key_ready  out  1  round-key store valid for the current key
in_valid  in  1  plaintext block valid
in_ready  out  1  core can accept a block
in_block  in  128  plaintext, MSB = byte 0
iv_in  in  128  CBC IV (used only with the optional feature)
out_valid  out  1  ciphertext valid
out_ready  in  1  sink accepts ciphertext
out_block  out  128  ciphertext

Behaviour:
- Reset: key_ready=0, in_ready=0, out_valid=0, out_block=0, both FSMs at IDLE. The round-key store is not cleared.
- Key FSM states: K_IDLE, K_EXPAND.
  - key_load=1 is honoured only when the encrypt FSM is E_IDLE. On that edge: register key_in as words w[0..Nk-1], drop key_ready, enter K_EXPAND.
  - K_EXPAND produces one word w[i] per cycle for i = Nk .. 4(Nr+1)-1, using the standard RotWord/SubWord/Rcon rules, including the extra SubWord at i mod 8 = 4 when KEY_BITS=256.
  - Expansion takes 40/46/52 cycles for 128/192/256. key_ready rises on the edge that writes the last word.
  - key_load while in K_EXPAND restarts expansion from the newly sampled key.
  - key_load while the encrypt FSM is not E_IDLE is dropped with no effect.
- in_ready = key_ready && encrypt FSM in E_IDLE && key FSM in K_IDLE.
- Encrypt FSM states: E_IDLE, E_ROUND, E_DONE.
  - Accept edge (edge 0), when in_valid && in_ready: state <= in_block ^ rk[0], round counter r <= 1, go to E_ROUND.
  - E_ROUND, edge r (1..Nr-1): SubBytes, ShiftRows, MixColumns, AddRoundKey rk[r].
  - Edge Nr: final round without MixColumns. out_block <= result, out_valid <= 1, go to E_DONE.
  - Latency: out_valid is high Nr clock edges after the accept edge (10/12/14).
- E_DONE: out_block and out_valid are held stable until out_valid && out_ready. On that edge: out_valid <= 0, go to E_IDLE. out_block keeps its last value.
- Throughput: one block per Nr+2 cycles when out_ready is tied high (in_ready is high the cycle after the output handshake).
- Round keys are read as rk[r] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}. The store is 4(Nr+1) x 32 registers.
- in_valid while in_ready=0 is ignored; the source holds the block until the handshake completes.
- Reset asserted mid-operation: all outputs return to reset values immediately; the block in flight is lost, and key_ready=0 until a new key_load.

Optional Feature:
AES_ENC_CBC_EN
- Defined: the core keeps a 128-bit chain register.
  - The first block accepted after each completed key expansion XORs iv_in into the plaintext before AddRoundKey rk[0].
  - Each later block XORs the previous out_block.
  - A new key_load resets the chain so the next block uses iv_in again.
- Undefined: ECB only. iv_in is unused and no chain register exists.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_block 3925841d02dc09fbdc118597196a0b32; key_ready 40 cycles after key_load; out_valid 10 edges after accept.
- KEY_BITS=192, key 000102..1617, pt 00112233445566778899aabbccddeeff -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 12; KEY_BITS=256, key 000102..1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, latency 14.
- Output backpressure: hold out_ready=0 for 20 cycles -> out_block and out_valid stable, in_ready=0 throughout; release -> one handshake, in_ready=1 next cycle.
- key_load during E_ROUND -> ignored, ciphertext still correct for the old key; key_load in E_IDLE mid-expansion -> key_ready only after a full 40-cycle expansion of the second key.
- reset_n low at round 5 -> out_valid=0, key_ready=0, in_ready=0 immediately; after reload, the FIPS-197 vector passes again.
- With AES_ENC_CBC_EN, KEY_BITS=128, SP800-38A F.2.1 key/IV, 4 blocks back-to-back -> ciphertexts 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2, 73bed6b8e3c1743b7116e69e22229516, 3ff1caa1681fac09120eca307586e1a7.
